mem_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit memory port among four requesters (IF fetch, LSU, debug, DMA slots 0..3). It selects one requester, drives its address, write data and write enable through a 4:1 32-bit select onto the memory port, waits for the memory handshake, and returns read data with a one-cycle done pulse. A watchdog aborts hung transactions. It sits between the pipeline/peripheral masters and the single data-memory interface.

---
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one 32-bit memory port among four
// requesters, with a watchdog that aborts accesses the memory never completes.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] addr2,
  input  logic [31:0] addr3,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [31:0] wdata2,
  input  logic [31:0] wdata3,
  input  logic [3:0]  we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [1:0]  sel,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [3:0]  err,
  output logic [31:0] rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ptr, pick;
  logic [CW-1:0]   cnt;
  logic            expired;
  logic [3:0][31:0] addr_v, wdata_v;

  assign addr_v  = {addr3, addr2, addr1, addr0};
  assign wdata_v = {wdata3, wdata2, wdata1, wdata0};

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--)
      if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|req) state_nxt = BUSY;
      BUSY: if (mem_ready || expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      sel   <= '0;
      cnt   <= '0;
      done  <= '0;
      err   <= '0;
      rdata <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: if (|req) begin
          sel <= pick;
          cnt <= '0;
        end
        BUSY: begin
          // A ready arriving on the last watchdog cycle still completes normally.
          if (mem_ready) begin
            done  <= 4'b0001 << sel;
            rdata <= mem_rdata;
            ptr   <= sel + 2'd1;
          end else if (expired) begin
            err <= 4'b0001 << sel;
            ptr <= sel + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = (state == BUSY);
  assign gnt       = mem_req ? (4'b0001 << sel) : 4'b0000;
  assign mem_we    = mem_req & we[sel];
  assign mem_addr  = addr_v[sel];
  assign mem_wdata = wdata_v[sel];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected completions are queued when
// requests are raised and retired against done/err pulses from the DUT.
module tb_mem_port_arbiter;
  localparam int TO = 4;
  localparam logic [31:0] K = 32'hDEADBFEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, we;
  logic [31:0] a [4];
  logic [31:0] wd [4];
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [1:0]  sel;
  logic [3:0]  gnt, done, err;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .addr0(a[0]), .addr1(a[1]), .addr2(a[2]), .addr3(a[3]),
    .wdata0(wd[0]), .wdata1(wd[1]), .wdata2(wd[2]), .wdata3(wd[3]),
    .we(we), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .sel(sel), .gnt(gnt), .done(done), .err(err), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    bit          is_err;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
    int          lat;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          busy_run = 0;
  logic [31:0] cur_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int idx, input bit is_err, input int lat);
    exp_t e;
    e.idx    = 2'(idx);
    e.is_err = is_err;
    e.addr   = a[idx];
    e.wdata  = wd[idx];
    e.we     = we[idx];
    e.lat    = lat;
    if (!is_err) cur_rd = a[idx] ^ K;
    e.rdata  = cur_rd;
    sb.push_back(e);
  endtask

  // One cycle: retire completions, check the port against the head entry,
  // then model the memory's response for the coming edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (done != 4'b0 || err != 4'b0) begin
      if (sb.size() == 0) begin
        chk("spurious_done_err", {24'h0, done, err}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("done", 32'(done), e.is_err ? 32'h0 : 32'(4'b0001 << e.idx));
        chk("err",  32'(err),  e.is_err ? 32'(4'b0001 << e.idx) : 32'h0);
        chk("rdata", rdata, e.rdata);
        chk("sel", 32'(sel), 32'(e.idx));
        chk("busy_cycles", 32'(busy_run), e.is_err ? 32'(TO) : 32'(e.lat + 1));
      end
      busy_run = 0;
    end
    if (mem_req) begin
      if (sb.size() == 0) begin
        chk("spurious_grant", 32'(gnt), 32'h0);
        mem_ready = 1'b0;
      end else begin
        e = sb[0];
        chk("gnt", 32'(gnt), 32'(4'b0001 << e.idx));
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        mem_ready = (busy_run == e.lat);
      end
      mem_rdata = mem_addr ^ K;
      busy_run++;
    end else begin
      chk("idle_mem_we", 32'(mem_we), 32'h0);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("budget_expired", 32'(sb.size()), 32'h0);
      sb.delete();
    end
    req = 4'b0;
    we  = 4'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0; we = 4'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = 32'h1000 + 32'(i) * 32'h10;
      wd[i] = 32'hA500_0000 + 32'(i);
    end
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single read with one wait state.
    a[1] = 32'h100;
    push(1, 1'b0, 1);
    req = 4'b0010;
    run(20);
    tick();

    // ptr now 2: requester 2 beats 0, then 0.
    push(2, 1'b0, 0);
    push(0, 1'b0, 0);
    req = 4'b0101;
    run(20);
    tick();

    // Round robin from ptr 1 with zero-wait memory.
    push(1, 1'b0, 0); push(2, 1'b0, 0); push(3, 1'b0, 0);
    push(0, 1'b0, 0); push(1, 1'b0, 0);
    req = 4'b1111;
    run(40);
    tick();

    // Write.
    a[2] = 32'h40; wd[2] = 32'h12345678; we = 4'b0100;
    push(2, 1'b0, 2);
    req = 4'b0100;
    run(20);
    tick();

    // Timeout on requester 0 (ptr 3 wraps to 0), then requester 1 is next.
    push(0, 1'b1, 1000);
    push(1, 1'b0, 1);
    req = 4'b0011;
    run(40);
    tick();

    // Ready on the last watchdog cycle completes, no err.
    push(2, 1'b0, TO - 1);
    req = 4'b0100;
    run(20);
    tick();

    // Reset mid-transaction.
    push(3, 1'b1, 1000);
    req = 4'b1000;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'h0);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    sb.delete();
    busy_run = 0;
    cur_rd = 32'h0;
    req = 4'b0;
    mem_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // ptr restarted at 0.
    push(0, 1'b0, 0); push(1, 1'b0, 0); push(2, 1'b0, 0);
    push(3, 1'b0, 0); push(0, 1'b0, 0);
    req = 4'b1111;
    run(40);
    push(3, 1'b0, 0);
    req = 4'b1000;
    run(20);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
